// File: rtl/out_port_ctrl_pkg.sv
// Shared types and defaults for the output-port controller (t_data, FSM enum, depth/skid).
// Optional statistics counters in out_port_ctrl are enabled by defining OUT_PORT_STATS_EN.
package out_port_ctrl_pkg;

    typedef logic [31:0] t_data;

    localparam int unsigned OUT_PORT_DEPTH = 4;
    localparam int unsigned OUT_PORT_SKID  = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } t_out_port_state;

endpackage

// File: rtl/out_port_fifo.sv
// Word buffer for the output port: storage, wrapping head/tail pointers and occupancy.
// Head word is read from registered state only; callers must not dequeue when empty.
module out_port_fifo
    import out_port_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = OUT_PORT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  logic                     deq,
    input  t_data                    wdata,
    output t_data                    rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    t_data          mem_q [DEPTH];
    t_data          mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;

    // DEPTH is a power of two, so pointer wrap is plain modular increment.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (enq) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rdata      = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign level_next = level_d;
    assign full       = (level_q == LW'(DEPTH));
    assign empty      = (level_q == '0);

endmodule

// File: rtl/out_port_ctrl.sv
// Output-port controller: buffers stage-3 words, drains them over valid/ready, drives the
// pipeline stall and a flush sequence. Define OUT_PORT_STATS_EN to add sent/drop counters.
module out_port_ctrl
    import out_port_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = OUT_PORT_DEPTH,
    parameter int unsigned SKID  = OUT_PORT_SKID
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dataoutvx3,
    input  t_data                    dataoutx3,
    input  logic                     stalledx3,
    output logic                     stalled,
    output t_data                    port_data,
    output logic                     port_valid,
    input  logic                     port_ready,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
`ifdef OUT_PORT_STATS_EN
    ,
    output logic [15:0]              sent_count,
    output logic [7:0]               drop_count
`endif
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic            push_req;
    logic            enq;
    logic            deq;
    logic            drop;
    logic            full;
    logic            empty;
    logic [LW-1:0]   level_next;

    t_out_port_state state_q, state_d;
    logic            stalled_q, stalled_d;
    logic            overflow_q, overflow_d;

    assign push_req = dataoutvx3 & ~stalledx3;
    assign deq      = port_valid & port_ready;
    assign enq      = push_req & (~full | deq);
    assign drop     = push_req & full & ~deq;

    out_port_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .enq        (enq),
        .deq        (deq),
        .wdata      (dataoutx3),
        .rdata      (port_data),
        .level      (level),
        .level_next (level_next),
        .full       (full),
        .empty      (empty)
    );

    assign port_valid = ~empty;

    // Words still in flight may land during FLUSH, so DONE waits for an empty FIFO with no enqueue.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush) state_d = FLUSH;
            FLUSH:   if ((level_next == '0) && !enq) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stalled_d  = (level_next >= LW'(DEPTH - SKID)) | (state_d == FLUSH);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            stalled_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stalled_q  <= stalled_d;
            overflow_q <= overflow_d;
        end
    end

    assign stalled    = stalled_q;
    assign overflow   = overflow_q;
    assign flush_done = (state_q == DONE);

`ifdef OUT_PORT_STATS_EN
    logic [15:0] sent_count_q, sent_count_d;
    logic [7:0]  drop_count_q, drop_count_d;

    always_comb begin
        sent_count_d = sent_count_q;
        drop_count_d = drop_count_q;
        if (deq) begin
            sent_count_d = sent_count_q + 16'd1;
        end
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sent_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            sent_count_q <= sent_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign sent_count = sent_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl: expected words queued on enqueue, compared on dequeue.
// Stats counters are checked too when OUT_PORT_STATS_EN is defined.
module tb_out_port_ctrl;
    import out_port_ctrl_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SKID  = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        dataoutvx3;
    t_data       dataoutx3;
    logic        stalledx3;
    logic        stalled;
    t_data       port_data;
    logic        port_valid;
    logic        port_ready;
    logic        flush;
    logic        flush_done;
    logic        overflow;
    logic [2:0]  level;
`ifdef OUT_PORT_STATS_EN
    logic [15:0] sent_count;
    logic [7:0]  drop_count;
`endif

    out_port_ctrl #(
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dataoutvx3 (dataoutvx3),
        .dataoutx3  (dataoutx3),
        .stalledx3  (stalledx3),
        .stalled    (stalled),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .overflow   (overflow),
        .level      (level)
`ifdef OUT_PORT_STATS_EN
        ,
        .sent_count (sent_count),
        .drop_count (drop_count)
`endif
    );

    always #5 clock = ~clock;

    int    n_tests = 0;
    int    n_fail  = 0;
    t_data exp_q[$];
    logic  exp_ovf;
    int    exp_state;   // 0 RUN, 1 FLUSH, 2 DONE
    int    exp_sent;
    int    exp_drop;
    int    done_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_state = 0;
        exp_sent  = 0;
        exp_drop  = 0;
    endtask

    task automatic check_reset_values();
        check("rst_level", level, 0);
        check("rst_valid", port_valid, 0);
        check("rst_stalled", stalled, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_overflow", overflow, 0);
`ifdef OUT_PORT_STATS_EN
        check("rst_sent", sent_count, 0);
        check("rst_drop", drop_count, 0);
`endif
    endtask

    // One clock: check head, advance the model with the driven inputs, then check after the edge.
    task automatic cycle();
        logic dq, push, eq;
        int   nxt;
        check("port_valid", port_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("port_data", port_data, exp_q[0]);
        dq   = (exp_q.size() != 0) && port_ready;
        push = dataoutvx3 && !stalledx3;
        eq   = push && ((exp_q.size() < DEPTH) || dq);
        if (dq) begin
            void'(exp_q.pop_front());
            exp_sent = (exp_sent + 1) % 65536;
        end
        if (eq) begin
            exp_q.push_back(dataoutx3);
        end else if (push) begin
            exp_ovf = 1'b1;
            if (exp_drop < 255) exp_drop++;
        end
        nxt = exp_state;
        case (exp_state)
            0: if (flush) nxt = 1;
            1: if (exp_q.size() == 0 && !eq) nxt = 2;
            default: nxt = 0;
        endcase
        exp_state = nxt;
        @(posedge clock);
        #1;
        check("level", level, exp_q.size());
        check("stalled", stalled, (exp_q.size() >= DEPTH - SKID) || (exp_state == 1));
        check("flush_done", flush_done, exp_state == 2);
        check("overflow", overflow, exp_ovf);
        if (flush_done) done_pulses++;
`ifdef OUT_PORT_STATS_EN
        check("sent_count", sent_count, exp_sent);
        check("drop_count", drop_count, exp_drop);
`endif
    endtask

    task automatic drive(input logic v, input logic s, input t_data d, input logic r);
        dataoutvx3 = v;
        stalledx3  = s;
        dataoutx3  = d;
        port_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 1'b0, 32'h55, 1'b1);
        model_reset();
        done_pulses = 0;

        // Reset held with valid input: nothing may enqueue.
        repeat (3) @(posedge clock);
        #1;
        check_reset_values();
        drive(1'b0, 1'b0, '0, 1'b1);
        reset = 1'b0;

        // Streaming with consumer ready.
        drive(1'b1, 1'b0, 32'h11, 1'b1); cycle();
        drive(1'b1, 1'b0, 32'h22, 1'b1); cycle();
        drive(1'b1, 1'b0, 32'h33, 1'b1); cycle();
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (2) cycle();

        // Consumer stalled: fill, stall rises, 5th word dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'hA0 + i, 1'b0);
            cycle();
        end
        check("overflow_set", overflow, 1);

        // Full with simultaneous enqueue and dequeue.
        drive(1'b1, 1'b0, 32'hB0, 1'b1); cycle();
        check("full_level", level, 4);
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (5) cycle();

        // Stage 3 stalled: no enqueue.
        drive(1'b1, 1'b1, 32'hEE, 1'b1);
        repeat (3) cycle();
        check("stallx3_level", level, 0);

        // Flush with three buffered words.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'hC0 + i, 1'b0);
            cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        done_pulses = 0;
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (8) cycle();
        check("flush_pulses", done_pulses, 1);

        // Reset asserted mid-flush.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'hD0 + i, 1'b0);
            cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        flush = 1'b1; cycle(); flush = 1'b0;
        cycle();
        reset = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        done_pulses = 0;
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (4) cycle();
        check("rst_flush_pulses", done_pulses, 0);

        // Back to normal operation after reset.
        drive(1'b1, 1'b0, 32'hF1, 1'b1); cycle();
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
